// File: rtl/tluh_xbar_pkg.sv
// Shared crossbar types: address/region types, error-responder states and the
// default main-crossbar memory map used to build per-instance region tables.
package tluh_xbar_pkg;

  localparam int unsigned XbarAddrWidth = 32;
  localparam int unsigned MainNumDev    = 10;

  typedef logic [XbarAddrWidth-1:0] addr_t;

  typedef struct packed {
    addr_t base;
    addr_t mask;
  } region_t;

  typedef enum logic {
    ERR_IDLE = 1'b0,
    ERR_RESP = 1'b1
  } err_st_e;

  typedef logic [MainNumDev-1:0][XbarAddrWidth-1:0] main_arr_t;

  // Index order: QSPI, ICCM, DCCM, TIMER0, TIMER1, TIMER2, TIC, PERIPH, PLIC, ROM
  localparam region_t MainMap [MainNumDev] = '{
    '{base: 32'h8000_0000, mask: 32'h0FFF_FFFF},
    '{base: 32'h1000_0000, mask: 32'h0001_FFFF},
    '{base: 32'h2000_0000, mask: 32'h0000_FFFF},
    '{base: 32'h3000_0000, mask: 32'h0000_0FFF},
    '{base: 32'h3000_1000, mask: 32'h0000_0FFF},
    '{base: 32'h3000_2000, mask: 32'h0000_0FFF},
    '{base: 32'h3001_0000, mask: 32'h0000_FFFF},
    '{base: 32'h3002_0000, mask: 32'h0000_FFFF},
    '{base: 32'h4800_0000, mask: 32'h03FF_FFFF},
    '{base: 32'h0000_0000, mask: 32'h0000_3FFF}
  };

  function automatic main_arr_t main_base();
    main_arr_t r;
    for (int i = 0; i < int'(MainNumDev); i++) r[i] = MainMap[i].base;
    return r;
  endfunction

  function automatic main_arr_t main_mask();
    main_arr_t r;
    for (int i = 0; i < int'(MainNumDev); i++) r[i] = MainMap[i].mask;
    return r;
  endfunction

endpackage

// File: rtl/tluh_err_resp.sv
// Built-in error responder: answers one unmapped request with an error beat,
// one cycle after accept, carrying the captured source ID.
//   state    | meaning
//   ERR_IDLE | no error response pending
//   ERR_RESP | error beat presented on D, held until host accepts
module tluh_err_resp
  import tluh_xbar_pkg::*;
#(
  parameter int unsigned SrcWidth = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                accept_i,
  input  logic [SrcWidth-1:0] src_i,
  input  logic                d_ready_i,
  output err_st_e             st_o,
  output logic                valid_o,
  output logic [SrcWidth-1:0] src_o
);

  err_st_e             err_st_q, err_st_d;
  logic [SrcWidth-1:0] err_src_q, err_src_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_st_q  <= ERR_IDLE;
      err_src_q <= '0;
    end else begin
      err_st_q  <= err_st_d;
      err_src_q <= err_src_d;
    end
  end

  always_comb begin
    err_st_d  = err_st_q;
    err_src_d = err_src_q;
    unique case (err_st_q)
      ERR_IDLE: begin
        if (accept_i) begin
          err_st_d  = ERR_RESP;
          err_src_d = src_i;
        end
      end
      ERR_RESP: begin
        if (d_ready_i) err_st_d = ERR_IDLE;
      end
      default: err_st_d = ERR_IDLE;
    endcase
  end

  assign st_o    = err_st_q;
  assign valid_o = (err_st_q == ERR_RESP);
  assign src_o   = err_src_q;

endmodule

// File: rtl/tluh_addr_steer.sv
// TL-UL 1:N address steering: decodes A requests against a base/mask region
// table, keeps D responses in order by only ever talking to one target at a time.
module tluh_addr_steer
  import tluh_xbar_pkg::*;
#(
  parameter int unsigned NumDev         = 10,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned SrcWidth       = 8,
  parameter int unsigned MaxOutstanding = 4,
  parameter logic [NumDev-1:0][AddrWidth-1:0] DevBase = '0,
  parameter logic [NumDev-1:0][AddrWidth-1:0] DevMask = '0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         a_valid_i,
  output logic                         a_ready_o,
  input  logic [AddrWidth-1:0]         a_address_i,
  input  logic [SrcWidth-1:0]          a_source_i,
  output logic [NumDev-1:0]            dev_a_valid_o,
  input  logic [NumDev-1:0]            dev_a_ready_i,
  input  logic [NumDev-1:0]            dev_d_valid_i,
  output logic [NumDev-1:0]            dev_d_ready_o,
  input  logic [NumDev-1:0]            dev_d_error_i,
  input  logic [NumDev*SrcWidth-1:0]   dev_d_source_i,
  output logic                         d_valid_o,
  input  logic                         d_ready_i,
  output logic                         d_error_o,
  output logic [SrcWidth-1:0]          d_source_o,
  output logic [$clog2(NumDev+1)-1:0]  d_dev_o
);

  localparam int unsigned TgtWidth = $clog2(NumDev + 1);
  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
  localparam logic [TgtWidth-1:0] ErrTgt = TgtWidth'(NumDev);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstanding);

  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [TgtWidth-1:0] sel_q, sel_d;
  logic [TgtWidth-1:0] tgt;
  logic                tgt_err, sel_err;
  logic                cnt_full, stall;
  logic                a_accept, d_hs;
  err_st_e             err_st;
  logic                err_valid;
  logic [SrcWidth-1:0] err_src;

  // Walk downwards so the lowest matching index is the one left standing.
  always_comb begin
    tgt = ErrTgt;
    for (int i = int'(NumDev) - 1; i >= 0; i--) begin
      if ((a_address_i & ~DevMask[i]) == DevBase[i]) tgt = TgtWidth'(i);
    end
  end

  assign tgt_err  = (tgt == ErrTgt);
  assign sel_err  = (sel_q == ErrTgt);
  assign cnt_full = (cnt_q == CntMax);
  // Switching targets only once everything in flight has returned keeps D in order.
  assign stall    = cnt_full
                 || ((cnt_q != '0) && (tgt != sel_q))
                 || (err_st == ERR_RESP);

  always_comb begin
    dev_a_valid_o = '0;
    a_ready_o     = 1'b0;
    if (!stall) begin
      if (tgt_err) begin
        a_ready_o = 1'b1;
      end else begin
        for (int i = 0; i < int'(NumDev); i++) begin
          if (tgt == TgtWidth'(i)) begin
            dev_a_valid_o[i] = a_valid_i;
            a_ready_o        = dev_a_ready_i[i];
          end
        end
      end
    end
  end

  assign a_accept = a_valid_i && a_ready_o;

  always_comb begin
    d_valid_o     = 1'b0;
    d_error_o     = 1'b0;
    d_source_o    = '0;
    dev_d_ready_o = '0;
    if (sel_err) begin
      d_valid_o  = err_valid;
      d_error_o  = 1'b1;
      d_source_o = err_src;
    end else begin
      for (int i = 0; i < int'(NumDev); i++) begin
        if (sel_q == TgtWidth'(i)) begin
          d_valid_o        = dev_d_valid_i[i];
          d_error_o        = dev_d_error_i[i];
          d_source_o       = dev_d_source_i[i*SrcWidth +: SrcWidth];
          dev_d_ready_o[i] = d_ready_i;
        end
      end
    end
  end

  assign d_hs    = d_valid_o && d_ready_i;
  assign d_dev_o = sel_q;

  always_comb begin
    cnt_d = cnt_q;
    sel_d = sel_q;
    if (a_accept) sel_d = tgt;
    if (a_accept && !d_hs) begin
      cnt_d = cnt_q + CntWidth'(1);
    end else if (!a_accept && d_hs && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      sel_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      sel_q <= sel_d;
    end
  end

  tluh_err_resp #(
    .SrcWidth (SrcWidth)
  ) u_err_resp (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .accept_i  (a_accept && tgt_err),
    .src_i     (a_source_i),
    .d_ready_i (d_ready_i),
    .st_o      (err_st),
    .valid_o   (err_valid),
    .src_o     (err_src)
  );

  a_valid_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(dev_a_valid_o));
  d_ready_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(dev_d_ready_o));
  no_accept_when_full : assert property (@(posedge clk_i) disable iff (rst_i)
    !(a_accept && cnt_full));
  no_d_without_request : assert property (@(posedge clk_i) disable iff (rst_i)
    !(d_hs && !a_accept && (cnt_q == '0)));

endmodule

// File: doc/tluh_addr_steer.md
Name: tluh_addr_steer

Overview:
- Parametrised TL-UL 1:N address steering block. It replaces the fixed main-crossbar memory map with per-instance region tables (base/mask arrays).
- A-channel: decodes the host request address and steers it to one of NumDev device ports.
- D-channel: tracks outstanding transactions so responses return strictly in order.
- Unmapped addresses are answered by a built-in error responder.
- Sits between a host port and the device sockets inside the main and peripheral crossbars.

Parameters:
- NumDev, 10, number of device ports (1..16).
- AddrWidth, 32, request address width.
- SrcWidth, 8, a_source/d_source width.
- MaxOutstanding, 4, maximum in-flight A beats awaiting a D response (1..15).
- DevBase, all-zero array [NumDev][AddrWidth], region base per device.
- DevMask, all-zero array [NumDev][AddrWidth], region offset mask per device (set bits = offset bits).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- a_valid_i  in  1  host A request valid
- a_ready_o  out  1  host A request accepted
- a_address_i  in  AddrWidth  request address
- a_source_i  in  SrcWidth  request source ID
- dev_a_valid_o  out  NumDev  one-hot A valid to devices
- dev_a_ready_i  in  NumDev  device A ready
- dev_d_valid_i  in  NumDev  device D valid
- dev_d_ready_o  out  NumDev  one-hot D ready to devices
- dev_d_error_i  in  NumDev  device D error
- dev_d_source_i  in  NumDev*SrcWidth  device D source
- d_valid_o  out  1  host D valid
- d_ready_i  in  1  host D ready
- d_error_o  out  1  host D error
- d_source_o  out  SrcWidth  host D source
- d_dev_o  out  $clog2(NumDev+1)  index of the responding target (NumDev = error responder)

Behaviour:
- Interface: one clock `clk_i`. Reset `rst_i` is synchronous and active-high.
- Decode (combinational):
  - dev i hits when (a_address_i & ~DevMask[i]) == DevBase[i].
  - On multiple hits, the lowest index wins.
  - No hit selects target NumDev (error responder).
- Registered state:
  - cnt_q: outstanding count, width $clog2(MaxOutstanding+1).
  - sel_q: current target index.
  - err_st_q: error responder state, ERR_IDLE or ERR_RESP.
  - err_src_q: SrcWidth.
- Stall condition. A is stalled when any of the following holds:
  - cnt_q == MaxOutstanding;
  - cnt_q != 0 and decoded target != sel_q;
  - err_st_q == ERR_RESP.
- A-channel outputs when not stalled:
  - Mapped target t: dev_a_valid_o[t] = a_valid_i and a_ready_o = dev_a_ready_i[t].
  - Error target: a_ready_o = 1.
  - Other dev_a_valid_o bits are 0. While stalled, all dev_a_valid_o are 0 and a_ready_o = 0.
- A accept (a_valid_i & a_ready_o):
  - sel_q <= target.
  - Error target: err_src_q <= a_source_i and err_st_q <= ERR_RESP.
- D-channel mux:
  - sel_q < NumDev: d_valid_o = dev_d_valid_i[sel_q]; d_error_o, d_source_o from device sel_q; dev_d_ready_o[sel_q] = d_ready_i, other bits 0.
  - sel_q == NumDev: d_valid_o = (err_st_q == ERR_RESP), d_error_o = 1, d_source_o = err_src_q, dev_d_ready_o = 0.
  - d_dev_o = sel_q.
- Error FSM:
  - ERR_IDLE -> ERR_RESP on accept of an unmapped request.
  - ERR_RESP -> ERR_IDLE on d_valid_o & d_ready_i.
  - Response appears the cycle after accept (latency 1) and is held until accepted.
- Counter:
  - +1 on A accept, -1 on D handshake; both in the same cycle leaves it unchanged.
  - Never wraps. A D handshake at cnt_q == 0 is a protocol violation: assertion fires and the counter holds 0.
  - Devices may respond in the same cycle as accept; this is combinationally legal and counted as above.
- Reset (mid-transaction included): cnt_q = 0, sel_q = 0, err_st_q = ERR_IDLE, err_src_q = 0.
  - Outputs during and after reset: a_ready_o = 0 unless a_valid_i decodes legally. dev_a_valid_o = 0, d_valid_o = 0 unless device 0 drives valid.
  - In-flight transactions are dropped; devices are reset by the same rst_i.
- Assertions:
  - dev_a_valid_o and dev_d_ready_o are one-hot0.
  - No A accept while cnt_q == MaxOutstanding.

Decomposition:
- Shared package tluh_xbar_pkg:
  - typedef addr_t (AddrWidth);
  - typedef region_t {base, mask};
  - default main-crossbar region arrays (QSPI/ICCM/DCCM/TIMER0-2/TIC/PERIPH/PLIC/ROM) as localparam region_t arrays feeding DevBase/DevMask;
  - err FSM enum.
- One sub-module: tluh_err_resp (error FSM plus source capture).

Test Plan:
- Main map, read 0x2000_0010 (DCCM, idx 2), device responds after 3 cycles -> dev_a_valid_o = 0x004; d_dev_o = 2; d_error_o = 0; cnt 1 -> 0.
- Unmapped address 0x7000_0000, source 0x5A -> a_ready_o = 1 on the same cycle; next cycle d_valid_o = 1, d_error_o = 1, d_source_o = 0x5A, d_dev_o = 10; a_ready_o held 0 until d_ready_i.
- Four back-to-back accepts to TIMER0 (0x3000_0000) with MaxOutstanding = 4 and no responses -> fifth request stalled (a_ready_o = 0); one D handshake -> fifth accepted the next cycle.
- Outstanding request to ICCM followed by a request to ROM -> ROM request stalled until the ICCM response handshakes, then routed to idx 9.
- Overlapping regions (dev1 base 0x4000_0000 mask 0xFFFF, dev3 base 0x4000_0000 mask 0xFF), address 0x4000_0004 -> dev 1 selected.
- rst_i asserted with cnt = 3 and ERR_RESP pending -> next cycle cnt 0, d_valid_o 0, new request accepted immediately.
